// File: rtl/line_buf_pair_pkg.sv
// rtl/line_buf_pair_pkg.sv - shared defaults and FSM encodings for line_buf_pair
// Default geometry is a 1280x360 line-doubler input; states are plain constants.
package line_buf_pair_pkg;

  localparam int LB_WIDTH  = 1280;
  localparam int LB_HEIGHT = 360;
  localparam int LB_DW     = 8;
  localparam int LB_CW     = 11;
  localparam int LB_LW     = 9;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LINE   = 2'd1;
  localparam logic [1:0] S_REPLAY = 2'd2;

endpackage

// File: rtl/line_buf_pair_line_ram.sv
// rtl/line_buf_pair_line_ram.sv - simple dual-port line RAM with registered read
// One write port and one read port; read data appears one clock after the address.
module line_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1280,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_buf_pair.sv
// rtl/line_buf_pair.sv - two-line ping-pong buffer feeding the column interpolator
// Optional bottom-edge replay line is built when LINE_BUF_REPLAY_EN is defined.
module line_buf_pair
  import line_buf_pair_pkg::*;
#(
  parameter int WIDTH  = LB_WIDTH,
  parameter int HEIGHT = LB_HEIGHT,
  parameter int DW     = LB_DW,
  parameter int CW     = LB_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_data_en,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] buf1_data_out,
  output logic [DW-1:0] buf2_data_out,
  output logic [CW-1:0] row_cnt,
  output logic [8:0]    line_cnt,
  output logic          o_data_en,
  output logic          ovf_err
);

  localparam int            AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_WIDTH  = CW'(WIDTH);
  localparam logic [CW-1:0] C_SAT    = CW'(WIDTH + 1);
  localparam logic [8:0]    C_HEIGHT = 9'(HEIGHT);
`ifdef LINE_BUF_REPLAY_EN
  localparam logic          C_REPLAY = 1'b1;
`else
  localparam logic          C_REPLAY = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic          r_en_d;
  logic          r_wr_sel;
  logic [8:0]    r_line_cnt;
  logic          r_wrap;
  logic          r_ovf;

  logic          r_v1;
  logic [DW-1:0] r_d1;
  logic [CW-1:0] r_col1;
  logic          r_first1;
  logic          r_rep1;
  logic          r_rd_sel1;

  logic          r_v2;
  logic [CW-1:0] r_row2;
  logic [DW-1:0] r_b1;
  logic [DW-1:0] r_b2;

  logic          w_start;
  logic          w_in_line;
  logic          w_end;
  logic          w_rep_start;
  logic          w_in_rep;
  logic          w_rep_px;
  logic          w_rep_last;
  logic [CW-1:0] w_col_inc;
  logic [CW-1:0] w_col;
  logic          w_wr;
  logic          w_v;
  logic          w_rd_sel;
  logic [CW-1:0] w_addr_full;
  logic [AW-1:0] w_addr;
  logic [8:0]    w_line_idx;
  logic          w_first;
  logic          w_ovf_hit;
  logic [DW-1:0] w_rd0;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd_data;

  // A line starts only on a rising enable; a level left high after replay is ignored.
  assign w_start     = (r_state == S_IDLE) && in_data_en && !r_en_d;
  assign w_in_line   = w_start || ((r_state == S_LINE) && in_data_en);
  assign w_end       = (r_state == S_LINE) && !in_data_en;
  assign w_rep_start = C_REPLAY && w_end && (r_line_cnt == C_HEIGHT);
  assign w_in_rep    = (r_state == S_REPLAY);
  assign w_rep_px    = w_rep_start || w_in_rep;
  assign w_col_inc   = (r_col == C_SAT) ? r_col : r_col + CW'(1);
  assign w_col       = w_rep_start ? CW'(1) : w_col_inc;
  assign w_rep_last  = w_in_rep && (w_col_inc >= C_WIDTH);
  assign w_wr        = w_in_line && (w_col_inc <= C_WIDTH);
  assign w_v         = w_wr || w_rep_px;
  assign w_ovf_hit   = (w_in_line && (w_col_inc > C_WIDTH)) || (w_in_rep && in_data_en);

  // Replay's first read happens before wr_sel flips, so it targets the bank just written.
  assign w_rd_sel    = w_rep_start ? r_wr_sel : ~r_wr_sel;
  assign w_addr_full = w_col - CW'(1);
  assign w_addr      = w_addr_full[AW-1:0];

  assign w_line_idx  = (w_start && ((r_line_cnt == 9'd0) || r_wrap)) ? 9'd1 : r_line_cnt;
  assign w_first     = (w_line_idx == 9'd1) && !w_rep_px;

  line_ram #(.DW(DW), .DEPTH(WIDTH), .AW(AW)) u_ram0 (
    .clk     (clk),
    .i_we    (w_wr && !r_wr_sel),
    .i_waddr (w_addr),
    .i_wdata (in_data),
    .i_raddr (w_addr),
    .o_rdata (w_rd0)
  );

  line_ram #(.DW(DW), .DEPTH(WIDTH), .AW(AW)) u_ram1 (
    .clk     (clk),
    .i_we    (w_wr && r_wr_sel),
    .i_waddr (w_addr),
    .i_wdata (in_data),
    .i_raddr (w_addr),
    .o_rdata (w_rd1)
  );

  assign w_rd_data = r_rd_sel1 ? w_rd1 : w_rd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start) r_state <= S_LINE;
        S_LINE:   if (w_end) r_state <= w_rep_start ? S_REPLAY : S_IDLE;
        S_REPLAY: if (w_rep_last) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_en_d   <= 1'b0;
      r_wr_sel <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_en_d <= in_data_en;
      if (w_end) begin
        r_col    <= w_rep_start ? CW'(1) : '0;
        r_wr_sel <= ~r_wr_sel;
      end else if (w_rep_last) begin
        r_col <= '0;
      end else if (w_in_line || w_in_rep) begin
        r_col <= w_col_inc;
      end
      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Line HEIGHT keeps its index through blanking/replay; the wrap lands on the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (w_start && ((r_line_cnt == 9'd0) || r_wrap)) begin
      r_line_cnt <= 9'd1;
      r_wrap     <= 1'b0;
    end else if (w_end) begin
      if (r_line_cnt == C_HEIGHT) begin
        r_wrap <= 1'b1;
      end else begin
        r_line_cnt <= r_line_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_col1    <= '0;
      r_first1  <= 1'b0;
      r_rep1    <= 1'b0;
      r_rd_sel1 <= 1'b0;
      r_v2      <= 1'b0;
      r_row2    <= '0;
      r_b1      <= '0;
      r_b2      <= '0;
    end else begin
      r_v1      <= w_v;
      r_d1      <= in_data;
      r_col1    <= w_col;
      r_first1  <= w_first;
      r_rep1    <= w_rep_px;
      r_rd_sel1 <= w_rd_sel;
      r_v2      <= r_v1;
      r_row2    <= r_v1 ? r_col1 : '0;
      r_b2      <= r_rep1 ? w_rd_data : r_d1;
      r_b1      <= r_first1 ? r_d1 : w_rd_data;
    end
  end

  assign o_data_en     = r_v2;
  assign row_cnt       = r_row2;
  assign buf1_data_out = r_b1;
  assign buf2_data_out = r_b2;
  assign line_cnt      = r_line_cnt;
  assign ovf_err       = r_ovf;

endmodule

// File: tb/tb_line_buf_pair.sv
// tb/tb_line_buf_pair.sv - directed self-checking bench for line_buf_pair
// Small geometry (20 px x 6 lines) keeps full-frame runs short.
module tb_line_buf_pair;

  localparam int W  = 20;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_data_en = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] buf1_data_out;
  logic [DW-1:0] buf2_data_out;
  logic [CW-1:0] row_cnt;
  logic [8:0]    line_cnt;
  logic          o_data_en;
  logic          ovf_err;

  line_buf_pair #(.WIDTH(W), .HEIGHT(H), .DW(DW), .CW(CW)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data_en    (in_data_en),
    .in_data       (in_data),
    .buf1_data_out (buf1_data_out),
    .buf2_data_out (buf2_data_out),
    .row_cnt       (row_cnt),
    .line_cnt      (line_cnt),
    .o_data_en     (o_data_en),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chk;
    logic          en;
    logic [CW-1:0] row;
    logic [7:0]    b1;
    logic [7:0]    b2;
  } exp_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         lb_line  = 0;
  exp_t       pipe0;
  exp_t       pipe1;
  logic [7:0] prev [W];
  logic [7:0] cur  [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int p, input int k);
    int v;
    case (p)
      0:       v = k;
      1:       v = 160;
      default: v = k * p + 13 * p;
    endcase
    return v[7:0];
  endfunction

  function automatic exp_t mk(input logic en, input int row, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    e.chk = 1'b1;
    e.en  = en;
    e.row = row[CW-1:0];
    e.b1  = b1;
    e.b2  = b2;
    return e;
  endfunction

  // Outputs at this negedge belong to the input driven two negedges earlier.
  task automatic step(input logic en, input logic [7:0] d, input exp_t e);
    logic [31:0] obs;
    logic [31:0] req;
    @(negedge clk);
    if (pipe1.chk) begin
      obs = {10'd0, o_data_en, row_cnt, pipe1.en ? buf1_data_out : 8'h00,
             pipe1.en ? buf2_data_out : 8'h00};
      req = {10'd0, pipe1.en, pipe1.row, pipe1.b1, pipe1.b2};
      check("pix", obs, req);
    end
    pipe1 = pipe0;
    pipe0 = e;
    in_data_en = en;
    in_data = d;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, mk(1'b0, 0, 8'h00, 8'h00));
  endtask

  task automatic send_line(input int n, input int pat, input int nblank);
    int         l;
    logic [7:0] d;
    l = (lb_line == 0 || lb_line == H) ? 1 : lb_line + 1;
    for (int k = 1; k <= n; k++) begin
      d = pix(pat, k);
      if (k <= W) begin
        cur[k-1] = d;
        step(1'b1, d, mk(1'b1, k, (l == 1) ? d : prev[k-1], d));
      end else begin
        step(1'b1, d, mk(1'b0, 0, 8'h00, 8'h00));
      end
      if (k == 2) check("line_cnt", 32'(line_cnt), 32'(l));
    end
    blank(nblank);
    for (int k = 0; k < W && k < n; k++) prev[k] = cur[k];
    lb_line = l;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pipe0 = '0;
    pipe1 = '0;
    repeat (3) @(negedge clk);
    check("rst_state", {o_data_en, row_cnt, buf1_data_out, buf2_data_out, line_cnt, ovf_err}, 32'd0);
    rst_n = 1'b1;
    blank(2);

    send_line(W, 0, 1);
    send_line(W, 1, 1);
    send_line(W, 5, 1);
    check("ovf_clear", 32'(ovf_err), 32'd0);

    send_line(W + 5, 7, 2);
    check("ovf_set", 32'(ovf_err), 32'd1);
    blank(3);
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    send_line(11, 9, 0);
    rst_n = 1'b0;
    pipe0 = '0;
    pipe1 = '0;
    @(posedge clk);
    #1;
    check("rst_mid", {o_data_en, row_cnt, buf1_data_out, buf2_data_out, line_cnt, ovf_err}, 32'd0);
    in_data_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lb_line = 0;
    blank(2);

    for (int l = 1; l <= H; l++) send_line(W, 20 + l, (l == H) ? 0 : 1);

`ifdef LINE_BUF_REPLAY_EN
    for (int k = 1; k <= W; k++)
      step((k == 6 || k == 7), 8'h55, mk(1'b1, k, prev[k-1], prev[k-1]));
    check("ovf_replay", 32'(ovf_err), 32'd1);
`else
    blank(W);
    check("ovf_no_replay", 32'(ovf_err), 32'd0);
`endif

    send_line(W, 3, 1);
    send_line(W, 4, 2);
    check("line_cnt_end", 32'(line_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
